// File: rtl/kws_bridge_pkg.sv
// Shared register map, bit positions and FSM state type for the KWS Wishbone bridge.
package kws_bridge_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_STATUS = 1;
  localparam int unsigned REG_FEAT   = 2;
  localparam int unsigned REG_RES    = 3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned CTRL_OP_LSB = 8;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_DONE      = 1;
  localparam int unsigned ST_FEAT_FULL = 2;
  localparam int unsigned ST_RES_EMPTY = 3;
  localparam int unsigned ST_OVF       = 4;
  localparam int unsigned ST_UNF       = 5;
  localparam int unsigned ST_START_ERR = 6;
  localparam int unsigned ST_FCNT_LSB  = 8;
  localparam int unsigned ST_RCNT_LSB  = 16;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/kws_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with flush; push ignored when full, pop ignored when empty.
module kws_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count   = wptr - rptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kws_wb_bridge.sv
// Wishbone slave front-end for the KWS core: control/status registers, feature and result FIFOs,
// run/done FSM, sticky error flags and a level interrupt.
module kws_wb_bridge
  import kws_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FEAT_DEPTH = 32,
  parameter int unsigned RES_DEPTH  = 16,
  parameter int unsigned OP_W       = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_dat_i,
  input  logic [31:0]     wbs_adr_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic            irq_o,
  output logic            core_start_o,
  output logic            core_abort_o,
  output logic [OP_W-1:0] core_opcode_o,
  output logic            core_feat_valid_o,
  input  logic            core_feat_ready_i,
  output logic [31:0]     core_feat_data_o,
  input  logic            core_res_valid_i,
  output logic            core_res_ready_o,
  input  logic [31:0]     core_res_data_i,
  input  logic            core_done_i
);

  localparam int unsigned IW  = ADDR_W - 2;
  localparam int unsigned FCW = $clog2(FEAT_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RES_DEPTH) + 1;

  state_t state_q, state_d;

  logic [IW-1:0]   idx;
  logic            access, wr, rd;
  logic            ctrl_wr, stat_wr, feat_wr, res_rd;
  logic            start_req, soft_clear, start_ok, start_bad, done_evt;
  logic            irq_en, done, ovf_err, unf_err, start_err;
  logic [OP_W-1:0] opcode;
  logic            ack_q, start_q, abort_q, irq_q;
  logic [31:0]     dat_q, rdata;

  logic            feat_full, feat_empty, feat_pop;
  logic [FCW-1:0]  feat_count;
  logic            res_full, res_empty;
  logic [RCW-1:0]  res_count;
  logic [31:0]     res_head;
  logic            unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:ADDR_W], wbs_adr_i[1:0]};

  // Bus decode: every side effect keys off the single access cycle.
  assign idx        = wbs_adr_i[ADDR_W-1:2];
  assign access     = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr         = access & wbs_we_i;
  assign rd         = access & ~wbs_we_i;
  assign ctrl_wr    = wr & (idx == IW'(REG_CTRL));
  assign stat_wr    = wr & (idx == IW'(REG_STATUS));
  assign feat_wr    = wr & (idx == IW'(REG_FEAT));
  assign res_rd     = rd & (idx == IW'(REG_RES));
  assign soft_clear = ctrl_wr & wbs_dat_i[CTRL_CLEAR];
  assign start_req  = ctrl_wr & wbs_dat_i[CTRL_START] & ~wbs_dat_i[CTRL_CLEAR];
  assign start_ok   = start_req & (state_q == IDLE);
  assign start_bad  = start_req & (state_q == RUN);
  assign done_evt   = core_done_i & (state_q == RUN) & ~soft_clear;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (soft_clear)    state_d = IDLE;
    else if (start_ok) state_d = RUN;
    else if (done_evt) state_d = IDLE;
  end

  // Sticky flags: a set event wins over a same-cycle W1C.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en    <= 1'b0;
      opcode    <= '0;
      done      <= 1'b0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      start_err <= 1'b0;
    end else begin
      if (ctrl_wr)  irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      if (start_ok) opcode <= wbs_dat_i[CTRL_OP_LSB +: OP_W];
      if (done_evt)                              done <= 1'b1;
      else if (start_ok)                         done <= 1'b0;
      else if (stat_wr && wbs_dat_i[ST_DONE])    done <= 1'b0;
      if (feat_wr && feat_full)                  ovf_err <= 1'b1;
      else if (stat_wr && wbs_dat_i[ST_OVF])     ovf_err <= 1'b0;
      if (res_rd && res_empty)                   unf_err <= 1'b1;
      else if (stat_wr && wbs_dat_i[ST_UNF])     unf_err <= 1'b0;
      if (start_bad)                             start_err <= 1'b1;
      else if (stat_wr && wbs_dat_i[ST_START_ERR]) start_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == IW'(REG_CTRL)) begin
      rdata[CTRL_IRQ_EN]            = irq_en;
      rdata[CTRL_OP_LSB +: OP_W]    = opcode;
    end else if (idx == IW'(REG_STATUS)) begin
      rdata[ST_BUSY]                = (state_q == RUN);
      rdata[ST_DONE]                = done;
      rdata[ST_FEAT_FULL]           = feat_full;
      rdata[ST_RES_EMPTY]           = res_empty;
      rdata[ST_OVF]                 = ovf_err;
      rdata[ST_UNF]                 = unf_err;
      rdata[ST_START_ERR]           = start_err;
      rdata[ST_FCNT_LSB +: CNT_W]   = CNT_W'(feat_count);
      rdata[ST_RCNT_LSB +: CNT_W]   = CNT_W'(res_count);
    end else if (idx == IW'(REG_RES)) begin
      rdata = res_empty ? '0 : res_head;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= access;
      dat_q   <= rd ? rdata : '0;
      start_q <= start_ok;
      abort_q <= soft_clear & (state_q == RUN);
      irq_q   <= irq_en & (done | ovf_err | unf_err | start_err);
    end
  end

  assign feat_pop = core_feat_valid_o & core_feat_ready_i;

  kws_sync_fifo #(.WIDTH(32), .DEPTH(FEAT_DEPTH)) u_feat_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (feat_wr),
    .pop   (feat_pop),
    .flush (soft_clear),
    .din   (wbs_dat_i),
    .dout  (core_feat_data_o),
    .full  (feat_full),
    .empty (feat_empty),
    .count (feat_count)
  );

  kws_sync_fifo #(.WIDTH(32), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (core_res_valid_i),
    .pop   (res_rd),
    .flush (soft_clear),
    .din   (core_res_data_i),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign wbs_ack_o         = ack_q;
  assign wbs_dat_o         = dat_q;
  assign irq_o             = irq_q;
  assign core_start_o      = start_q;
  assign core_abort_o      = abort_q;
  assign core_opcode_o     = opcode;
  assign core_feat_valid_o = (state_q == RUN) & ~feat_empty;
  assign core_res_ready_o  = ~res_full;

endmodule

// File: doc/kws_wb_bridge.md
Name: kws_wb_bridge

Overview:
- Parametrised Wishbone slave front-end for the KWS accelerator; next generation of the top-level bus wrapper.
- Adds a registered control/status map, an input feature FIFO that streams to the pipeline core, a result FIFO drained by the host, a run/done state machine, sticky error flags and a level interrupt.
- Sits between the Caravel Wishbone port and the cmvn→linear→relu core. The core is reached only through valid/ready streams plus start/done/abort.

Parameters:
- ADDR_W, 10, number of decoded byte-address bits; word index = wbs_adr_i[ADDR_W-1:2].
- FEAT_DEPTH, 32, feature FIFO depth in 32-bit words; power of two, ≥2.
- RES_DEPTH, 16, result FIFO depth in 32-bit words; power of two, ≥2.
- OP_W, 4, opcode width.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, every access is a full word.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  registered read data.
- irq_o  out  1  level interrupt.
- core_start_o  out  1  one-cycle start pulse.
- core_abort_o  out  1  one-cycle abort pulse.
- core_opcode_o  out  OP_W  latched opcode.
- core_feat_valid_o / core_feat_ready_i  out/in  1  feature stream handshake.
- core_feat_data_o  out  32  feature FIFO head.
- core_res_valid_i / core_res_ready_o  in/out  1  result stream handshake.
- core_res_data_i  in  32  result word.
- core_done_i  in  1  one-cycle pulse: core finished.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; both FIFOs empty; opcode=0; irq_en, done, err flags all 0.
- Bus timing:
  - access = cyc&stb&~ack.
  - ack rises the cycle after access and stays high for exactly one cycle; back-to-back accesses therefore take 2 cycles each.
  - All side effects (push, pop, W1C, start) occur once, in the access cycle.
  - Read data is registered with ack and is 0 in all other cycles.
- Register map (word index):
  - 0 CTRL. W: bit0 start, bit1 soft_clear, bit2 irq_en, [7+OP_W:8] opcode. R: {irq_en, opcode} at the same positions, bits0/1 read 0.
  - 1 STATUS. R: bit0 busy, bit1 done, bit2 feat_full, bit3 res_empty, bit4 ovf_err, bit5 unf_err, bit6 start_err, [15:8] feat_count, [23:16] res_count. W: 1s in bits1,4,5,6 clear those flags (W1C).
  - 2 FEAT_DATA. W pushes wbs_dat_i. If full, data is dropped and ovf_err set. R returns 0.
  - 3 RES_DATA. R pops and returns the head. If empty, returns 0 and sets unf_err. W is ignored.
  - Other indices: acked; read 0; writes ignored.
- FSM states: IDLE, RUN.
  - IDLE→RUN: CTRL write with start=1 and soft_clear=0. In that cycle: latch opcode, pulse core_start_o the next cycle, clear done.
  - start while RUN: ignored, sets start_err.
  - RUN→IDLE: on core_done_i; set done the same edge.
  - core_done_i while IDLE: ignored.
- soft_clear (any state):
  - Flushes both FIFOs and returns the FSM to IDLE.
  - Pulses core_abort_o if the FSM was in RUN.
  - Error flags are kept. If start and soft_clear are both 1, soft_clear wins.
- Feature stream: core_feat_valid_o = RUN & !feat_empty. Pop on valid&ready.
- Result stream: core_res_ready_o = !res_full, in all states. Push on valid&ready.
- FIFO simultaneous events:
  - Push is accepted iff not full at the clock edge, even if a pop occurs the same cycle.
  - Pop is accepted iff not empty; push and pop on an empty FIFO only pushes.
  - Count stays consistent: push+pop on a non-empty, non-full FIFO leaves count unchanged.
- Counts are $clog2(DEPTH)+1 bits wide and zero-extended/truncated into their 8-bit STATUS fields.
- irq_o = irq_en & (done | ovf_err | unf_err | start_err), registered (one-cycle delay from flag set).
- Reset mid-operation is asynchronous: immediate return to the reset values above. No abort pulse.

Decomposition:
- Package kws_bridge_pkg holds:
  - register word indices REG_CTRL=0, REG_STATUS=1, REG_FEAT=2, REG_RES=3;
  - CTRL/STATUS bit positions;
  - FSM state typedef {IDLE, RUN}.
- One sub-module, kws_sync_fifo (WIDTH, DEPTH):
  - ports push, pop, din, dout (head, first-word-fall-through), full, empty, count, flush;
  - instantiated twice.

Test Plan:
- Reset then read STATUS → 0x0000_0008 (res_empty only); ack high exactly one cycle, 1 cycle after stb.
- Push 3 features (0x11, 0x22, 0x33); write CTRL=0x0000_0501 (opcode 5, start). Expected:
  - core_start_o pulses once, core_opcode_o=5;
  - with ready tied high, the core receives 0x11, 0x22, 0x33 on consecutive cycles;
  - STATUS.busy=1.
- With irq_en=1, core pushes results 0xA, 0xB then pulses core_done_i. Expected:
  - STATUS done=1, res_count=2, irq_o=1;
  - two RES_DATA reads return 0xA then 0xB; a third returns 0 and sets unf_err;
  - writing STATUS=0x32 clears done/unf_err and drops irq_o.
- Push FEAT_DEPTH+1 words while IDLE → feat_full=1, ovf_err=1, feat_count=FEAT_DEPTH; the extra word is never streamed.
- Start while RUN → start_err=1, no second core_start_o. Soft_clear during RUN → core_abort_o pulses, busy=0, both counts=0.
- Assert wb_rst_i mid-RUN with a pending ack → ack, irq, core pulses drop asynchronously and STATUS reads 0x8 after release.
